mxu_scheduler: RTL and testbench
================================

# mxu_scheduler

Sequencing and arbitration front end for the shared `multiplier` matrix unit. Up to `NUM_REQ` clients submit A/B matrix pairs over valid/ready request ports. The scheduler grants one client at a time, round-robin, and launches the job with a start pulse. It waits for `finished` or a timeout, then returns the result tagged with the requester ID on a single valid/ready response port. It sits between the client fabric and the `multiplier` instance and owns the multiplier's reset.

## Interface
- `DIM`, 4, matrix dimension
- `WIDTH`, 8, input element width
- `OUT_WIDTH`, 32, output element width
- `NUM_REQ`, 4, number of requesters (≥2)
- `TIMEOUT`, 256, max WAIT cycles before abort (≥2)
- Derived: `MW = DIM*DIM*WIDTH`, `YW = DIM*DIM*OUT_WIDTH`, `IDW = $clog2(NUM_REQ)`
- `clk` in 1 — single clock, all logic on posedge
- `reset` in 1 — synchronous, active-high
- `req_valid` in NUM_REQ — per-client request valid
- `req_ready` out NUM_REQ — per-client accept (one-hot or zero)
- `req_a` in NUM_REQ*MW — client i's A at `[i*MW +: MW]`; element [r][c] at `[(r*DIM+c)*WIDTH +: WIDTH]`
- `req_b` in NUM_REQ*MW — same packing for B
- `rsp_valid` out 1 — result available
- `rsp_ready` in 1 — consumer accepts result
- `rsp_id` out IDW — requester index of result
- `rsp_data` out YW — result matrix, same [r][c] packing with OUT_WIDTH
- `rsp_err` out 1 — 1 = job aborted by timeout, `rsp_data` = 0
- `mxu_in0`, `mxu_in1` out MW — operands to multiplier
- `mxu_start` out 1 — one-cycle launch pulse
- `mxu_reset_n` out 1 — multiplier reset, active-low
- `mxu_out` in YW — multiplier result
- `mxu_finished` in 1 — multiplier done
- `busy` out 1 — state ≠ IDLE
- `jobs_done` out 16 — successful responses handed off, wraps
- `jobs_aborted` out 16 — timeout responses handed off, wraps

## Operation
- FSM: IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE:
  - Round-robin grant among asserted `req_valid`. Search starts at `last_grant+1` mod NUM_REQ.
  - `req_ready[g]=1` combinationally for the winner only. The handshake completes this cycle.
  - On handshake: latch `req_a[g]`, `req_b[g]` into operand registers and `g` into the ID register; set `last_grant=g`; go to ISSUE.
  - No `req_valid`: stay in IDLE, `req_ready=0`.
- ISSUE: `mxu_start=1` for exactly this cycle; clear the timer; go to WAIT.
- `mxu_in0`/`mxu_in1` are driven from the operand registers. They are stable from ISSUE until the next grant.
- WAIT: the timer increments each cycle.
  - `mxu_finished=1`: latch `mxu_out`, set `rsp_err=0`, go to RESP.
  - Otherwise, on the TIMEOUT-th WAIT cycle: set `rsp_data=0`, `rsp_err=1`, go to RESP.
  - Finished and timeout in the same cycle: finished wins.
- RESP:
  - `rsp_valid=1`. `rsp_id`, `rsp_data` and `rsp_err` are held stable until handshake.
  - On `rsp_valid&rsp_ready`: increment `jobs_done` or `jobs_aborted` per `rsp_err`, then go to IDLE.
- `mxu_finished` is ignored outside WAIT.
- Abort recovery: `mxu_reset_n=0` for exactly the first RESP cycle of an error response. Otherwise it is 1.
- `req_ready` is 0 for all clients in every state except IDLE.

## Timing
- Reset values:
  - State IDLE, `last_grant=NUM_REQ-1` (client 0 has first priority).
  - Outputs zero: `req_ready`, `rsp_valid`, `rsp_id`, `rsp_data`, `rsp_err`, `mxu_in0`, `mxu_in1`, `mxu_start`, `busy`, both counters.
  - `mxu_reset_n=0` while `reset=1`.
- Reset mid-job: on the next edge, return to IDLE. The in-flight job and any pending response are dropped, with no response and no counter update.
- Request accepted in cycle T → `mxu_start` in T+1 → WAIT from T+2.
- `mxu_finished` sampled high in WAIT cycle W → `rsp_valid` from W+1.
- Response handshake in cycle R → IDLE in R+1, where the next grant can occur.
- Minimum job occupancy is 4 cycles; there is no overlap of jobs.
- Timeout: with no `finished`, `rsp_valid` rises T+2+TIMEOUT cycles after acceptance.
- `rsp_valid` is never dropped before `rsp_ready`. `rsp_ready` held low stalls indefinitely; no timeout applies in RESP.
- Counters wrap from 16'hFFFF to 0.

## Test plan
- Single job, multiplier stub with 5-cycle latency, client 2: A=identity, B=[[1..16]] → one `mxu_start` pulse, `rsp_valid` with `rsp_id=2`, `rsp_data`=B, `rsp_err=0`, `jobs_done=1`.
- All four `req_valid` held for 8 jobs → grant order 0,1,2,3,0,1,2,3; each `rsp_id` matches.
- Stub never asserts finished, TIMEOUT=256 → `rsp_valid` 258 cycles after acceptance, `rsp_err=1`, `rsp_data=0`, `mxu_reset_n` low for one cycle, `jobs_aborted=1`.
- `mxu_finished` on WAIT cycle 256 (same cycle as timeout) → `rsp_err=0`, result latched.
- `rsp_ready` low 20 cycles with client 1 pending → `rsp_*` stable, `req_ready[1]=0`. On release, client 1 is granted the cycle after the handshake.
- `reset` pulsed during WAIT → next cycle `busy=0`, `rsp_valid=0`, counters 0, no response ever emitted for the dropped job.

Source files
------------

// File: rtl/mxu_scheduler.sv
// Round-robin front end for the shared matrix multiplier: grants one client, launches the job,
// waits for finished or timeout, then returns the tagged result on a single response port.
module mxu_scheduler #(
  parameter int DIM       = 4,
  parameter int WIDTH     = 8,
  parameter int OUT_WIDTH = 32,
  parameter int NUM_REQ   = 4,
  parameter int TIMEOUT   = 256,
  localparam int MW  = DIM*DIM*WIDTH,
  localparam int YW  = DIM*DIM*OUT_WIDTH,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*MW-1:0]  req_a,
  input  logic [NUM_REQ*MW-1:0]  req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [YW-1:0]          rsp_data,
  output logic                   rsp_err,
  output logic [MW-1:0]          mxu_in0,
  output logic [MW-1:0]          mxu_in1,
  output logic                   mxu_start,
  output logic                   mxu_reset_n,
  input  logic [YW-1:0]          mxu_out,
  input  logic                   mxu_finished,
  output logic                   busy,
  output logic [15:0]            jobs_done,
  output logic [15:0]            jobs_aborted
);

  localparam int TW = $clog2(TIMEOUT+1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic [1:0]     state;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] grant_idx;
  logic           grant_found;
  int             cand;
  logic [IDW-1:0] id_q;
  logic [MW-1:0]  op_a;
  logic [MW-1:0]  op_b;
  logic [TW-1:0]  timer;
  logic           timeout_hit;
  logic [YW-1:0]  data_q;
  logic           err_q;
  logic           resp_first;
  logic [15:0]    done_cnt;
  logic [15:0]    abort_cnt;

  // Search starts one past the previous winner so every client is served in turn.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_grant) + k) % NUM_REQ;
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(cand);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == ST_IDLE && grant_found)
      req_ready[grant_idx] = 1'b1;
  end

  // Timer reads k-1 on the k-th WAIT cycle.
  assign timeout_hit = (timer == TW'(TIMEOUT-1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_grant <= IDW'(NUM_REQ-1);
      id_q       <= '0;
      op_a       <= '0;
      op_b       <= '0;
      timer      <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      resp_first <= 1'b0;
      done_cnt   <= '0;
      abort_cnt  <= '0;
    end else begin
      resp_first <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_found) begin
            op_a       <= req_a[int'(grant_idx)*MW +: MW];
            op_b       <= req_b[int'(grant_idx)*MW +: MW];
            id_q       <= grant_idx;
            last_grant <= grant_idx;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          timer <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          timer <= timer + 1'b1;
          // A finish arriving on the timeout cycle still counts as success.
          if (mxu_finished) begin
            data_q     <= mxu_out;
            err_q      <= 1'b0;
            resp_first <= 1'b1;
            state      <= ST_RESP;
          end else if (timeout_hit) begin
            data_q     <= '0;
            err_q      <= 1'b1;
            resp_first <= 1'b1;
            state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            if (err_q) abort_cnt <= abort_cnt + 16'd1;
            else       done_cnt  <= done_cnt + 16'd1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid    = (state == ST_RESP);
  assign rsp_id       = id_q;
  assign rsp_data     = data_q;
  assign rsp_err      = err_q;
  assign mxu_in0      = op_a;
  assign mxu_in1      = op_b;
  assign mxu_start    = (state == ST_ISSUE);
  // Pulse the multiplier reset once after an abort so a hung job is cleared.
  assign mxu_reset_n  = ~reset & ~((state == ST_RESP) & err_q & resp_first);
  assign busy         = (state != ST_IDLE);
  assign jobs_done    = done_cnt;
  assign jobs_aborted = abort_cnt;

endmodule

// File: tb/tb_mxu_scheduler.sv
// Directed bench for mxu_scheduler with a behavioural multiplier stub of programmable latency.
module tb_mxu_scheduler;

  localparam int DIM       = 4;
  localparam int WIDTH     = 8;
  localparam int OUT_WIDTH = 32;
  localparam int NUM_REQ   = 4;
  localparam int TIMEOUT   = 256;
  localparam int MW        = DIM*DIM*WIDTH;
  localparam int YW        = DIM*DIM*OUT_WIDTH;
  localparam int IDW       = $clog2(NUM_REQ);

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*MW-1:0] req_a;
  logic [NUM_REQ*MW-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [YW-1:0]         rsp_data;
  logic                  rsp_err;
  logic [MW-1:0]         mxu_in0;
  logic [MW-1:0]         mxu_in1;
  logic                  mxu_start;
  logic                  mxu_reset_n;
  logic [YW-1:0]         mxu_out;
  logic                  mxu_finished;
  logic                  busy;
  logic [15:0]           jobs_done;
  logic [15:0]           jobs_aborted;

  int n_chk  = 0;
  int n_fail = 0;

  mxu_scheduler #(.DIM(DIM), .WIDTH(WIDTH), .OUT_WIDTH(OUT_WIDTH), .NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mxu_in0(mxu_in0), .mxu_in1(mxu_in1), .mxu_start(mxu_start), .mxu_reset_n(mxu_reset_n),
    .mxu_out(mxu_out), .mxu_finished(mxu_finished), .busy(busy),
    .jobs_done(jobs_done), .jobs_aborted(jobs_aborted)
  );

  always #5 clk = ~clk;

  // Multiplier stub: finished on the stub_lat-th WAIT cycle; stub_lat = 0 never finishes.
  int            stub_lat = 5;
  int            stub_cnt = 0;
  logic [YW-1:0] stub_res = '0;

  function automatic logic [YW-1:0] matmul(input logic [MW-1:0] a, input logic [MW-1:0] b);
    logic [YW-1:0]        y;
    logic [OUT_WIDTH-1:0] acc;
    y = '0;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        acc = '0;
        for (int k = 0; k < DIM; k++)
          acc = acc + OUT_WIDTH'(a[(r*DIM+k)*WIDTH +: WIDTH]) * OUT_WIDTH'(b[(k*DIM+c)*WIDTH +: WIDTH]);
        y[(r*DIM+c)*OUT_WIDTH +: OUT_WIDTH] = acc;
      end
    return y;
  endfunction

  always @(posedge clk) begin
    if (mxu_start) begin
      stub_cnt <= stub_lat;
      stub_res <= matmul(mxu_in0, mxu_in1);
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
    end
  end
  assign mxu_finished = (stub_cnt == 1);
  assign mxu_out      = stub_res;

  // Client i: A = identity (2*identity for client 3), B[k] = k+1+16*((i+2)%4); client 2 gets 1..16.
  function automatic logic [YW-1:0] exp_data(input int i);
    logic [YW-1:0] y;
    y = '0;
    for (int k = 0; k < DIM*DIM; k++)
      y[k*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'((k + 1 + 16*((i+2)%4)) * ((i == 3) ? 2 : 1));
    return y;
  endfunction

  task automatic chk(input string name, input logic [YW-1:0] act, input logic [YW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (!rsp_valid && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // One complete job: request with mask, check grant, latency, response, one stall cycle, handshake.
  task automatic run_job(input logic [3:0] mask, input int exp_id, input int exp_lat,
                         input logic [YW-1:0] exp_d, input logic exp_err);
    int            cyc;
    int            starts;
    logic [YW-1:0] onehot;
    onehot = '0;
    onehot[exp_id] = 1'b1;
    @(negedge clk);
    req_valid = mask;
    #1;
    chk("req_ready_grant", YW'(req_ready), onehot);
    @(negedge clk);
    req_valid = '0;
    cyc = 1;
    starts = mxu_start ? 1 : 0;
    while (!rsp_valid && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (mxu_start) starts++;
    end
    chk("rsp_latency", cyc, exp_lat);
    chk("start_pulses", starts, 1);
    chk("rsp_id", YW'(rsp_id), exp_id);
    chk("rsp_data", rsp_data, exp_d);
    chk("rsp_err", YW'(rsp_err), YW'(exp_err));
    chk("mxu_reset_n_first_resp", YW'(mxu_reset_n), YW'(!exp_err));
    @(negedge clk);
    chk("rsp_valid_held", YW'(rsp_valid), 1);
    chk("mxu_reset_n_second_resp", YW'(mxu_reset_n), 1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("busy_after_handshake", YW'(busy), 0);
  endtask

  typedef struct packed {
    logic [3:0] mask;
    int         exp_id;
  } vec_t;

  vec_t tbl [15];

  initial begin
    int cyc;
    int bad;
    int seen;

    tbl[0]  = '{4'b1111, 0};
    tbl[1]  = '{4'b1111, 1};
    tbl[2]  = '{4'b1111, 2};
    tbl[3]  = '{4'b1111, 3};
    tbl[4]  = '{4'b1111, 0};
    tbl[5]  = '{4'b1111, 1};
    tbl[6]  = '{4'b1111, 2};
    tbl[7]  = '{4'b1111, 3};
    tbl[8]  = '{4'b1010, 1};
    tbl[9]  = '{4'b1010, 3};
    tbl[10] = '{4'b0001, 0};
    tbl[11] = '{4'b0110, 1};
    tbl[12] = '{4'b0100, 2};
    tbl[13] = '{4'b1001, 3};
    tbl[14] = '{4'b1001, 0};

    req_a = '0;
    req_b = '0;
    for (int i = 0; i < NUM_REQ; i++)
      for (int k = 0; k < DIM*DIM; k++) begin
        req_a[i*MW + k*WIDTH +: WIDTH] = (k % (DIM+1) == 0) ? ((i == 3) ? 8'd2 : 8'd1) : 8'd0;
        req_b[i*MW + k*WIDTH +: WIDTH] = WIDTH'(k + 1 + 16*((i+2)%4));
      end

    reset = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_busy", YW'(busy), 0);
    chk("reset_rsp_valid", YW'(rsp_valid), 0);
    chk("reset_req_ready", YW'(req_ready), 0);
    chk("reset_mxu_start", YW'(mxu_start), 0);
    chk("reset_mxu_reset_n", YW'(mxu_reset_n), 0);
    chk("reset_mxu_in0", YW'(mxu_in0), 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_jobs_done", YW'(jobs_done), 0);
    reset = 1'b0;
    #1;
    chk("mxu_reset_n_released", YW'(mxu_reset_n), 1);

    // Single job for client 2 (identity x B), then abort, then finish on the timeout cycle.
    stub_lat = 5;
    run_job(4'b0100, 2, 7, exp_data(2), 1'b0);
    chk("jobs_done_single", YW'(jobs_done), 1);
    stub_lat = 0;
    run_job(4'b0001, 0, TIMEOUT+2, '0, 1'b1);
    chk("jobs_aborted_timeout", YW'(jobs_aborted), 1);
    stub_lat = TIMEOUT;
    run_job(4'b0001, 0, TIMEOUT+2, exp_data(0), 1'b0);
    chk("jobs_done_tie", YW'(jobs_done), 2);
    chk("jobs_aborted_tie", YW'(jobs_aborted), 1);

    // Round-robin table from a fresh reset.
    do_reset();
    stub_lat = 3;
    for (int v = 0; v < 15; v++)
      run_job(tbl[v].mask, tbl[v].exp_id, 5, exp_data(tbl[v].exp_id), 1'b0);
    chk("jobs_done_table", YW'(jobs_done), 15);
    chk("jobs_aborted_table", YW'(jobs_aborted), 0);

    // Response stall with client 1 pending.
    do_reset();
    stub_lat = 4;
    @(negedge clk);
    req_valid = 4'b0001;
    #1;
    chk("stall_grant0", YW'(req_ready), 4'b0001);
    @(negedge clk);
    req_valid = 4'b0010;
    wait_rsp(cyc);
    chk("stall_rsp_seen", YW'(rsp_valid), 1);
    bad = 0;
    for (int s = 0; s < 20; s++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== exp_data(0) ||
          rsp_err !== 1'b0 || req_ready !== 4'b0000)
        bad++;
    end
    chk("stall_stable_cycles_bad", bad, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk("stall_next_grant", YW'(req_ready), 4'b0010);
    chk("stall_jobs_done", YW'(jobs_done), 1);
    @(negedge clk);
    req_valid = '0;
    wait_rsp(cyc);
    chk("stall_second_id", YW'(rsp_id), 1);
    chk("stall_second_data", rsp_data, exp_data(1));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("stall_jobs_done2", YW'(jobs_done), 2);

    // Reset during WAIT drops the job.
    stub_lat = 0;
    @(negedge clk);
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    chk("midreset_busy_before", YW'(busy), 1);
    reset = 1'b1;
    #1;
    chk("midreset_mxu_reset_n", YW'(mxu_reset_n), 0);
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_busy", YW'(busy), 0);
    chk("midreset_rsp_valid", YW'(rsp_valid), 0);
    chk("midreset_jobs_done", YW'(jobs_done), 0);
    chk("midreset_jobs_aborted", YW'(jobs_aborted), 0);
    seen = 0;
    for (int s = 0; s < 300; s++) begin
      @(negedge clk);
      if (rsp_valid || busy) seen++;
    end
    chk("midreset_no_response", seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
